// File: rtl/pipe_ctrl.sv
// pipe_ctrl: control unit for the 3-stage RV32I pipeline (IF, DE, MW).
//   Decodes the DE instruction into datapath selects, carries write-back and
//   memory control into MW through a registered stage, and drives stall,
//   flush and forward controls for RAW hazards, redirects and memory waits.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   instr_de, br_taken          DE instruction and its branch compare result
//   dmem_ready                  data-memory completion for the MW access
//   imm_sel, alu_op, sel_a,
//   sel_b, br_type, illegal     combinational DE decode
//   pc_sel, flush_de            redirect to the ALU target, squash IF/DE
//   stall_if, stall_de          hold PC and IF/DE
//   fwd_a, fwd_b                select MW write-back data for rs1/rs2
//   reg_wr_mw, rd_mw, wb_sel_mw,
//   mem_rd_mw, mem_wr_mw,
//   mem_f3_mw                   registered MW-stage control
//   mem_err                     sticky memory-timeout flag
// Build option: define PIPE_FORWARD_EN to resolve RAW hazards by forwarding
//   from MW instead of a one-cycle stall.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_de,
  input  logic        br_taken,
  input  logic        dmem_ready,
  output logic [2:0]  imm_sel,
  output logic [3:0]  alu_op,
  output logic        sel_a,
  output logic        sel_b,
  output logic [2:0]  br_type,
  output logic        pc_sel,
  output logic        stall_if,
  output logic        stall_de,
  output logic        flush_de,
  output logic        fwd_a,
  output logic        fwd_b,
  output logic        reg_wr_mw,
  output logic [4:0]  rd_mw,
  output logic [1:0]  wb_sel_mw,
  output logic        mem_rd_mw,
  output logic        mem_wr_mw,
  output logic [2:0]  mem_f3_mw,
  output logic        illegal,
  output logic        mem_err
);
  localparam int CW = ($clog2(MEM_TIMEOUT) > 4) ? $clog2(MEM_TIMEOUT) : 4;
  localparam logic [CW-1:0] CNT_MAX = CW'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic       reg_wr;
    logic [4:0] rd;
    logic [1:0] wb_sel;
    logic       mem_rd;
    logic       mem_wr;
    logic [2:0] f3;
  } mw_t;

  typedef enum logic {S_RUN, S_WAIT} mstate_e;

  logic [6:0] opc;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic       f7_5;
  assign opc  = instr_de[6:0];
  assign rd   = instr_de[11:7];
  assign f3   = instr_de[14:12];
  assign rs1  = instr_de[19:15];
  assign rs2  = instr_de[24:20];
  assign f7_5 = instr_de[30];

  logic unused_bits;
  assign unused_bits = ^{instr_de[31], instr_de[29:25]};

  // ---------------- decode ----------------
  logic       reg_wr, mem_rd, mem_wr, use_rs1, use_rs2, is_jump, is_br;
  logic [1:0] wb_sel;

  always_comb begin
    imm_sel = 3'd0;
    alu_op  = 4'b0000;
    sel_a   = 1'b0;
    sel_b   = 1'b0;
    br_type = 3'd0;
    wb_sel  = 2'd0;
    reg_wr  = 1'b1;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    is_jump = 1'b0;
    is_br   = 1'b0;
    illegal = 1'b0;
    case (opc)
      OP_R:    begin alu_op = {f7_5, f3}; use_rs2 = 1'b1; end
      OP_I:    begin alu_op = {(f3 == 3'b101) & f7_5, f3}; sel_b = 1'b1; end
      OP_LD:   begin sel_b = 1'b1; mem_rd = 1'b1; wb_sel = 2'd1; end
      OP_ST:   begin
        sel_b = 1'b1; imm_sel = 3'd1; mem_wr = 1'b1; reg_wr = 1'b0; use_rs2 = 1'b1;
      end
      OP_BR:   begin
        sel_a = 1'b1; sel_b = 1'b1; imm_sel = 3'd3; reg_wr = 1'b0;
        use_rs2 = 1'b1; is_br = 1'b1; br_type = f3;
      end
      // PC-relative ops need the immediate on B to form PC+imm
      OP_JAL:  begin
        sel_a = 1'b1; sel_b = 1'b1; imm_sel = 3'd4; wb_sel = 2'd2;
        is_jump = 1'b1; use_rs1 = 1'b0;
      end
      OP_JALR: begin sel_b = 1'b1; wb_sel = 2'd2; is_jump = 1'b1; end
      OP_LUI:  begin alu_op = 4'b1111; sel_b = 1'b1; imm_sel = 3'd2; use_rs1 = 1'b0; end
      OP_AUIPC: begin sel_a = 1'b1; sel_b = 1'b1; imm_sel = 3'd2; use_rs1 = 1'b0; end
      // unsupported: behave as addi x0,x0,0
      default: begin illegal = 1'b1; sel_b = 1'b1; reg_wr = 1'b0; use_rs1 = 1'b0; end
    endcase
    if (rd == 5'd0) reg_wr = 1'b0;
  end

  // ---------------- MW stage / memory wait ----------------
  mw_t           mw_q, mw_d;
  mstate_e       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_stall, timeout;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_stall = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      S_RUN: if ((mw_q.mem_rd | mw_q.mem_wr) && !dmem_ready) begin
        mem_stall = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (dmem_ready) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          // give up: access is retired as if complete
          state_d = S_RUN;
          cnt_d   = '0;
          timeout = 1'b1;
        end else begin
          mem_stall = 1'b1;
          cnt_d     = cnt_q + CW'(1);
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // ---------------- hazards / redirect ----------------
  logic hz_a, hz_b, raw_stall, redirect;
  assign hz_a = mw_q.reg_wr && use_rs1 && (rs1 == mw_q.rd);
  assign hz_b = mw_q.reg_wr && use_rs2 && (rs2 == mw_q.rd);

`ifdef PIPE_FORWARD_EN
  assign raw_stall = 1'b0;
  assign fwd_a     = hz_a && !mem_stall;
  assign fwd_b     = hz_b && !mem_stall;
`else
  assign raw_stall = (hz_a || hz_b) && !mem_stall;
  assign fwd_a     = 1'b0;
  assign fwd_b     = 1'b0;
`endif

  // a hazarded branch is resolved only once its operands are available
  assign redirect = (is_jump || (is_br && br_taken)) && !mem_stall && !raw_stall;
  assign pc_sel   = redirect;
  assign flush_de = redirect;
  assign stall_if = mem_stall || raw_stall;
  assign stall_de = mem_stall || raw_stall;

  // The redirecting instruction itself still enters MW (JAL/JALR link
  // write); the squashed successor arrives later as the NOP put into IF/DE.
  always_comb begin
    mw_d = '{reg_wr: reg_wr, rd: rd, wb_sel: wb_sel,
             mem_rd: mem_rd, mem_wr: mem_wr, f3: f3};
    if (mem_stall)      mw_d = mw_q;
    else if (raw_stall) mw_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      mw_q    <= '0;
      mem_err <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mw_q    <= mw_d;
      if (timeout) mem_err <= 1'b1;
    end
  end

  // write-back is held off until the MW memory access completes
  assign reg_wr_mw = mw_q.reg_wr && !mem_stall;
  assign rd_mw     = mw_q.rd;
  assign wb_sel_mw = mw_q.wb_sel;
  assign mem_rd_mw = mw_q.mem_rd;
  assign mem_wr_mw = mw_q.mem_wr;
  assign mem_f3_mw = mw_q.f3;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed test-plan sequences plus a
// random instruction stream, all compared against a behavioural model.
module tb_pipe_ctrl;
  localparam int MEM_TIMEOUT = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] instr_de = NOP;
  logic        br_taken = 1'b0, dmem_ready = 1'b1;
  logic [2:0]  imm_sel, br_type, mem_f3_mw;
  logic [3:0]  alu_op;
  logic        sel_a, sel_b, pc_sel, stall_if, stall_de, flush_de, fwd_a, fwd_b;
  logic        reg_wr_mw, mem_rd_mw, mem_wr_mw, illegal, mem_err;
  logic [4:0]  rd_mw;
  logic [1:0]  wb_sel_mw;

  always #5 clk = ~clk;

  pipe_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .instr_de(instr_de), .br_taken(br_taken),
    .dmem_ready(dmem_ready), .imm_sel(imm_sel), .alu_op(alu_op), .sel_a(sel_a),
    .sel_b(sel_b), .br_type(br_type), .pc_sel(pc_sel), .stall_if(stall_if),
    .stall_de(stall_de), .flush_de(flush_de), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .reg_wr_mw(reg_wr_mw), .rd_mw(rd_mw), .wb_sel_mw(wb_sel_mw),
    .mem_rd_mw(mem_rd_mw), .mem_wr_mw(mem_wr_mw), .mem_f3_mw(mem_f3_mw),
    .illegal(illegal), .mem_err(mem_err)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [2:0] imm;
    logic [3:0] alu;
    logic       sa, sb, sb_chk;
    logic       wr;
    logic [1:0] wb;
    logic       ld, st, use1, use2, jmp, br, ill;
  } dec_t;

  // decode table straight from the opcode list
  function automatic dec_t ref_dec(input logic [31:0] i);
    dec_t d;
    logic [2:0] f3;
    f3 = i[14:12];
    d = '0;
    d.sb_chk = 1'b1; d.wr = 1'b1; d.use1 = 1'b1;
    case (i[6:0])
      7'b0110011: begin d.alu = {i[30], f3}; d.use2 = 1'b1; end
      7'b0010011: begin d.alu = {(f3 == 3'b101) ? i[30] : 1'b0, f3}; d.sb = 1'b1; end
      7'b0000011: begin d.sb = 1'b1; d.ld = 1'b1; d.wb = 2'd1; end
      7'b0100011: begin d.sb = 1'b1; d.imm = 3'd1; d.st = 1'b1; d.wr = 1'b0; d.use2 = 1'b1; end
      7'b1100011: begin
        d.sa = 1'b1; d.sb = 1'b1; d.imm = 3'd3; d.wr = 1'b0; d.use2 = 1'b1; d.br = 1'b1;
      end
      7'b1101111: begin
        d.sa = 1'b1; d.imm = 3'd4; d.wb = 2'd2; d.jmp = 1'b1; d.use1 = 1'b0; d.sb_chk = 1'b0;
      end
      7'b1100111: begin d.sb = 1'b1; d.wb = 2'd2; d.jmp = 1'b1; end
      7'b0110111: begin d.alu = 4'b1111; d.imm = 3'd2; d.use1 = 1'b0; d.sb_chk = 1'b0; end
      7'b0010111: begin d.sa = 1'b1; d.imm = 3'd2; d.use1 = 1'b0; d.sb_chk = 1'b0; end
      default:    begin d.ill = 1'b1; d.sb = 1'b1; d.wr = 1'b0; d.use1 = 1'b0; end
    endcase
    if (i[11:7] == 5'd0) d.wr = 1'b0;
    return d;
  endfunction

  // MW contents, stalled cycles spent on the current access, sticky error
  logic       m_wr, m_ld, m_st, m_err;
  logic [4:0] m_rd;
  logic [1:0] m_wb;
  logic [2:0] m_f3;
  int         m_n;

  task automatic model_reset();
    m_wr = 0; m_ld = 0; m_st = 0; m_err = 0; m_rd = 0; m_wb = 0; m_f3 = 0; m_n = 0;
  endtask

  // One pipeline cycle: drive, compare, clock, advance the model.
  task automatic step(input logic [31:0] ins, input logic tk, input logic rdy,
                      output logic est, output logic efl, output logic ost);
    dec_t d;
    logic acc, ms, rs, ha, hb, efa, efb, redir;
    instr_de = ins; br_taken = tk; dmem_ready = rdy;
    #2;
    d   = ref_dec(ins);
    acc = m_ld || m_st;
    ms  = acc && !rdy && (m_n < MEM_TIMEOUT);
    ha  = m_wr && d.use1 && (ins[19:15] == m_rd);
    hb  = m_wr && d.use2 && (ins[24:20] == m_rd);
`ifdef PIPE_FORWARD_EN
    rs = 1'b0; efa = ha && !ms; efb = hb && !ms;
`else
    rs = (ha || hb) && !ms; efa = 1'b0; efb = 1'b0;
`endif
    redir = (d.jmp || (d.br && tk)) && !ms && !rs;
    chk("imm_sel", imm_sel, d.imm);
    chk("alu_op", alu_op, d.alu);
    chk("sel_a", sel_a, d.sa);
    if (d.sb_chk) chk("sel_b", sel_b, d.sb);
    if (d.br) chk("br_type", br_type, ins[14:12]);
    chk("illegal", illegal, d.ill);
    chk("pc_sel", pc_sel, redir);
    chk("flush_de", flush_de, redir);
    chk("stall_if", stall_if, ms || rs);
    chk("stall_de", stall_de, ms || rs);
    chk("fwd_a", fwd_a, efa);
    chk("fwd_b", fwd_b, efb);
    chk("reg_wr_mw", reg_wr_mw, m_wr && !ms);
    chk("mem_rd_mw", mem_rd_mw, m_ld);
    chk("mem_wr_mw", mem_wr_mw, m_st);
    if (m_wr || m_ld || m_st) begin
      chk("rd_mw", rd_mw, m_rd);
      chk("wb_sel_mw", wb_sel_mw, m_wb);
      chk("mem_f3_mw", mem_f3_mw, m_f3);
    end
    chk("mem_err", mem_err, m_err);
    est = ms || rs; efl = redir; ost = stall_if;
    @(posedge clk);
    if (ms) m_n++;
    else begin
      if (acc && !rdy) m_err = 1'b1;
      m_n = 0;
      if (rs) begin
        m_wr = 0; m_ld = 0; m_st = 0; m_rd = 0; m_wb = 0; m_f3 = 0;
      end else begin
        m_wr = d.wr; m_ld = d.ld; m_st = d.st; m_rd = ins[11:7]; m_wb = d.wb; m_f3 = ins[14:12];
      end
    end
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  op;
    int          sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0: op = 7'b0110011;  1: op = 7'b0010011;  2: op = 7'b0000011;
      3: op = 7'b0100011;  4: op = 7'b1100011;  5: op = 7'b1101111;
      6: op = 7'b1100111;  7: op = 7'b0110111;  8: op = 7'b0010111;
      default: op = 7'b1111111;
    endcase
    r = $urandom;
    r[6:0]   = op;
    r[11:7]  = 5'($urandom_range(0, 3));
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    return r;
  endfunction

  initial begin
    logic st, fl, ost;
    logic [31:0] cur;
    int n;
    model_reset();
    // reset state
    #3;
    chk("rst_reg_wr_mw", reg_wr_mw, 0);
    chk("rst_mem_rd_mw", mem_rd_mw, 0);
    chk("rst_stall_if", stall_if, 0);
    chk("rst_mem_err", mem_err, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // arithmetic RAW: addi x1,x0,5 ; add x2,x1,x1
    step(32'h0050_0093, 0, 1, st, fl, ost);
    step(32'h0010_8133, 0, 1, st, fl, ost);
    if (st) step(32'h0010_8133, 0, 1, st, fl, ost);
    step(NOP, 0, 1, st, fl, ost);

    // taken branch: beq x0,x0 then the squashed slot as NOP
    step(32'h0000_0063, 1, 1, st, fl, ost);
    chk("br_flush", fl, 1);
    step(NOP, 0, 1, st, fl, ost);

    // delayed load: lw x3,0(x0), ready low for 3 MW cycles
    step(32'h0000_2183, 0, 1, st, fl, ost);
    n = 0;
    for (int k = 0; k < 3; k++) begin
      step(NOP, 0, 0, st, fl, ost);
      if (ost) n++;
    end
    step(NOP, 0, 1, st, fl, ost);
    chk("ld_stall_cycles", n, 3);
    chk("ld_release", ost, 0);

    // decode sweep: LUI x5, JAL x1 (+ flushed slot), illegal opcode
    step(32'h1234_52B7, 0, 1, st, fl, ost);
    step(32'h0000_00EF, 0, 1, st, fl, ost);
    step(NOP, 0, 1, st, fl, ost);
    step(32'h0000_007F, 0, 1, st, fl, ost);
    step(NOP, 0, 1, st, fl, ost);

    // random instruction stream with pipeline-accurate hold / squash
    cur = rand_instr();
    for (int k = 0; k < 3000; k++) begin
      step(cur, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7), st, fl, ost);
      if (!st) cur = fl ? NOP : rand_instr();
    end
    for (int k = 0; k < 3; k++) step(NOP, 0, 1, st, fl, ost);

    // timeout: sw x1,0(x0) with ready held low
    step(32'h0010_2023, 0, 1, st, fl, ost);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      step(NOP, 0, 0, st, fl, ost);
      if (ost) n++;
      else break;
    end
    chk("to_stall_cycles", n, MEM_TIMEOUT);
    chk("to_mem_err", mem_err, 1);
    step(NOP, 0, 0, st, fl, ost);
    chk("to_sticky", mem_err, 1);

    // reset while waiting on a load
    step(32'h0000_2183, 0, 1, st, fl, ost);
    step(NOP, 0, 0, st, fl, ost);
    step(NOP, 0, 0, st, fl, ost);
    chk("pre_rst_stall", stall_if, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_stall_if", stall_if, 0);
    chk("arst_stall_de", stall_de, 0);
    chk("arst_reg_wr_mw", reg_wr_mw, 0);
    chk("arst_mem_rd_mw", mem_rd_mw, 0);
    chk("arst_mem_err", mem_err, 0);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    step(NOP, 0, 0, st, fl, ost);
    chk("post_rst_run", ost, 0);
    step(32'h0050_0093, 0, 1, st, fl, ost);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
